bmp280_spi_target: RTL and testbench

- SPI mode-0 target that emulates the BMP280 register interface, i.e. the responder end of the SPI master used for sensor access.
- Lets the SPI master be verified in closed loop on-chip and in simulation without the physical sensor.
- Oversamples csb/sck/sdi on clk12MHz and decodes BMP280-style transactions (R/W bit + 7-bit address, burst reads, address/data write pairs).
- Serves a 16-byte register window plus a read-only chip-ID byte; local logic loads the window through a parallel port.

---
 rtl/bmp280_spi_pkg.sv | 15 +
 rtl/spi_sync_edge.sv | 34 +++
 rtl/bmp280_spi_target.sv | 160 ++++++++++++++++
 tb/tb_bmp280_spi_target.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bmp280_spi_pkg.sv
// Shared types and constants for the BMP280 SPI target emulator.
package bmp280_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_RD,
    ST_WR_DATA,
    ST_WR_ADDR
  } state_t;

  localparam logic [6:0] CHIP_ID_ADDR = 7'h50;
  localparam int         RW_BIT       = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// N-stage input synchronizer with single-cycle rise/fall pulses on the
// synchronized level.
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;

  // NOTE: non-blocking assignments make every stage sample the previous
  // stage's old value, so the chain really is STAGES flops deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_prev <= r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = o_q & ~r_prev;
  assign o_fall = ~o_q & r_prev;

endmodule

// File: rtl/bmp280_spi_target.sv
// SPI mode-0 target emulating the BMP280 register interface: chip-ID byte plus
// a 16-byte window loadable from a local parallel port.
module bmp280_spi_target
  import bmp280_spi_pkg::*;
#(
  parameter logic [7:0] CHIP_ID     = 8'h58,
  parameter logic [6:0] REG_BASE    = 7'h70,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk12MHz,
  input  logic       rst_n,
  input  logic       csb,
  input  logic       sck,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_oe,
  input  logic       host_wr_en,
  input  logic [3:0] host_wr_addr,
  input  logic [7:0] host_wr_data,
  output logic       spi_wr_strobe,
  output logic [3:0] spi_wr_addr,
  output logic [7:0] spi_wr_data,
  output logic       busy
);

  function automatic logic in_window(input logic [6:0] a);
    return (a >= REG_BASE) && (a <= REG_BASE + 7'd15);
  endfunction

  function automatic logic [3:0] win_off(input logic [6:0] a);
    logic [6:0] d;
    d = a - REG_BASE;
    return d[3:0];
  endfunction

  function automatic logic [6:0] next_addr(input logic [6:0] a);
    logic [3:0] o;
    o = win_off(a) + 4'd1;
    return in_window(a) ? REG_BASE + {3'b000, o} : a + 7'd1;
  endfunction

  logic w_csb, w_csb_rise, w_csb_fall;
  logic w_sck, w_sck_rise, w_sck_fall;
  logic w_sdi, w_sdi_rise, w_sdi_fall;
  logic w_unused;

  // csb resets low so that a falling edge needs csb seen high after reset.
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_csb (
    .clk(clk12MHz), .rst_n(rst_n), .i_d(csb),
    .o_q(w_csb), .o_rise(w_csb_rise), .o_fall(w_csb_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk12MHz), .rst_n(rst_n), .i_d(sck),
    .o_q(w_sck), .o_rise(w_sck_rise), .o_fall(w_sck_fall));
  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
    .clk(clk12MHz), .rst_n(rst_n), .i_d(sdi),
    .o_q(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall));

  assign w_unused = ^{w_sck, w_sdi_rise, w_sdi_fall};

  state_t     r_state, w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift, r_tx;
  logic [6:0] r_addr, w_rd_addr;
  logic [7:0] r_mem [16];
  logic       r_armed;
  logic [7:0] w_byte, w_rd_data;
  logic       w_last, w_load, w_commit;
  logic [3:0] w_wr_off;

  assign w_byte   = {r_shift[6:0], w_sdi};
  assign w_last   = w_sck_rise && (r_bit_cnt == 3'd7);
  assign w_wr_off = win_off(r_addr);
  assign busy     = r_armed & ~w_csb;

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_rd_addr   = r_addr;
    w_load      = 1'b0;
    w_commit    = 1'b0;
    if (w_csb_rise) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_csb_fall) w_state_nxt = ST_ADDR;
        ST_ADDR, ST_WR_ADDR: if (w_last) begin
          w_rd_addr   = w_byte[6:0];
          w_load      = w_byte[RW_BIT];
          w_state_nxt = w_byte[RW_BIT] ? ST_RD : ST_WR_DATA;
        end
        ST_RD: if (w_last) begin
          w_rd_addr = next_addr(r_addr);
          w_load    = 1'b1;
        end
        ST_WR_DATA: if (w_last) begin
          w_commit    = in_window(r_addr);
          w_state_nxt = ST_WR_ADDR;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_rd_data = (w_rd_addr == CHIP_ID_ADDR) ? CHIP_ID :
                     in_window(w_rd_addr) ? r_mem[win_off(w_rd_addr)] : 8'h00;

  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_tx          <= 8'h00;
      r_addr        <= 7'h00;
      r_armed       <= 1'b0;
      sdo           <= 1'b0;
      sdo_oe        <= 1'b0;
      spi_wr_strobe <= 1'b0;
      spi_wr_addr   <= 4'h0;
      spi_wr_data   <= 8'h00;
    end else begin
      r_state       <= w_state_nxt;
      r_armed       <= r_armed | w_csb;
      spi_wr_strobe <= w_commit;
      if (w_commit) begin
        spi_wr_addr <= w_wr_off;
        spi_wr_data <= w_byte;
      end
      if (w_csb_rise || r_state == ST_IDLE) begin
        r_bit_cnt <= 3'd0;
        sdo       <= 1'b0;
        sdo_oe    <= 1'b0;
      end else begin
        if (w_sck_rise) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (w_last && r_state != ST_WR_DATA) r_addr <= w_rd_addr;
          if (w_load) r_tx <= w_rd_data;
        end
        if (w_sck_fall && r_state == ST_RD) begin
          sdo    <= r_tx[7];
          r_tx   <= {r_tx[6:0], 1'b0};
          sdo_oe <= 1'b1;
        end
      end
    end
  end

  // NOTE: the window is a handful of flops that must read 8'h00 after reset,
  // so it is reset explicitly rather than treated as an uninitialised RAM.
  always_ff @(posedge clk12MHz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) r_mem[i] <= 8'h00;
    end else begin
      if (host_wr_en) r_mem[host_wr_addr] <= host_wr_data;
      if (w_commit)   r_mem[w_wr_off]     <= w_byte;
    end
  end

endmodule

// File: tb/tb_bmp280_spi_target.sv
// Self-checking bench: SPI master model, read-data scoreboard, write-strobe
// monitor, a table of single-byte reads and hand-written corner sequences.
module tb_bmp280_spi_target;

  localparam int SYNC = 2;
  localparam int HALF = 6;

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] exp;
  } rd_vec_t;

  logic       clk12MHz = 1'b0;
  logic       rst_n = 1'b0;
  logic       csb = 1'b1;
  logic       sck = 1'b0;
  logic       sdi = 1'b0;
  logic       host_wr_en = 1'b0;
  logic [3:0] host_wr_addr = 4'h0;
  logic [7:0] host_wr_data = 8'h00;
  logic       sdo, sdo_oe, spi_wr_strobe, busy;
  logic [3:0] spi_wr_addr;
  logic [7:0] spi_wr_data;

  bmp280_spi_target #(.CHIP_ID(8'h58), .REG_BASE(7'h70), .SYNC_STAGES(SYNC)) dut (
    .clk12MHz(clk12MHz), .rst_n(rst_n), .csb(csb), .sck(sck), .sdi(sdi),
    .sdo(sdo), .sdo_oe(sdo_oe),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .spi_wr_strobe(spi_wr_strobe), .spi_wr_addr(spi_wr_addr), .spi_wr_data(spi_wr_data),
    .busy(busy));

  always #5 clk12MHz = ~clk12MHz;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  exp_q[$];
  logic [11:0] exp_wr_q[$];
  logic [11:0] got_wr_q[$];
  rd_vec_t     vecs[10];

  always @(negedge clk12MHz) if (spi_wr_strobe) got_wr_q.push_back({spi_wr_addr, spi_wr_data});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic half_wait();
    repeat (HALF) @(negedge clk12MHz);
  endtask

  task automatic cs_low();
    @(negedge clk12MHz);
    csb = 1'b0;
    half_wait();
  endtask

  task automatic cs_high();
    half_wait();
    csb = 1'b1;
    half_wait();
    half_wait();
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk12MHz);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    @(negedge clk12MHz);
    host_wr_en = 1'b0;
  endtask

  // One mode-0 bit; with collide set, a host write to offset 3 is timed to land
  // in the same cycle as the SPI commit triggered by this rising edge.
  task automatic spi_bit(input logic b, input logic collide, output logic so, output logic oe);
    sdi = b;
    half_wait();
    so = sdo;
    oe = sdo_oe;
    sck = 1'b1;
    if (collide) begin
      repeat (SYNC) @(posedge clk12MHz);
      @(negedge clk12MHz);
      host_wr_en = 1'b1; host_wr_addr = 4'h3; host_wr_data = 8'h55;
      @(negedge clk12MHz);
      host_wr_en = 1'b0;
      repeat (HALF - SYNC - 1) @(negedge clk12MHz);
    end else begin
      half_wait();
    end
    sck = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, input int collide_bit,
                          output logic [7:0] rx, output int oe_cnt);
    logic so, oe;
    oe_cnt = 0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], (i == collide_bit), so, oe);
      rx[i] = so;
      oe_cnt += int'(oe);
    end
  endtask

  task automatic read_frame(input logic [7:0] cmd, input int n, input string name,
                            output int oe_addr, output int oe_data);
    logic [7:0] rx, e;
    int c;
    cs_low();
    spi_byte(cmd, -1, rx, oe_addr);
    oe_data = 0;
    for (int k = 0; k < n; k++) begin
      spi_byte(8'h00, -1, rx, c);
      oe_data += c;
      if (exp_q.size() == 0) begin
        check($sformatf("%s scoreboard underflow", name), 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check($sformatf("%s byte%0d", name, k), rx, e);
      end
    end
    cs_high();
  endtask

  task automatic write_frame(input logic [7:0] b0, input logic [7:0] b1);
    logic [7:0] rx;
    int c;
    spi_byte(b0, -1, rx, c);
    spi_byte(b1, -1, rx, c);
  endtask

  task automatic check_writes(input string name);
    logic [11:0] g, e;
    check($sformatf("%s strobe count", name), got_wr_q.size(), exp_wr_q.size());
    while (got_wr_q.size() > 0 && exp_wr_q.size() > 0) begin
      g = got_wr_q.pop_front();
      e = exp_wr_q.pop_front();
      check($sformatf("%s {offset,data}", name), g, e);
    end
    got_wr_q.delete();
    exp_wr_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, " sdo"}, sdo, 0);
    check({name, " sdo_oe"}, sdo_oe, 0);
    check({name, " strobe"}, spi_wr_strobe, 0);
    check({name, " wr_addr"}, spi_wr_addr, 0);
    check({name, " wr_data"}, spi_wr_data, 0);
    check({name, " busy"}, busy, 0);
  endtask

  initial begin
    int oa, od, c1, c2;
    logic [7:0] rx;
    logic so, oe;
    logic [2:0] part;

    repeat (3) @(negedge clk12MHz);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) @(negedge clk12MHz);
    check("idle busy", busy, 0);

    // Chip ID
    exp_q.push_back(8'h58);
    read_frame(8'hD0, 1, "chip_id", oa, od);
    check("chip_id sdo_oe during address", oa, 0);
    check("chip_id sdo_oe during data", od, 8);
    check("chip_id sdo_oe after csb", sdo_oe, 0);
    check("chip_id busy after csb", busy, 0);
    check_writes("chip_id");

    // Single write then read back
    cs_low();
    write_frame(8'h75, 8'hA5);
    cs_high();
    exp_wr_q.push_back({4'h5, 8'hA5});
    check_writes("single_write");
    exp_q.push_back(8'hA5);
    read_frame(8'hF5, 1, "readback_F5", oa, od);

    // Burst read across the window wrap
    host_write(4'd14, 8'h11);
    host_write(4'd15, 8'h22);
    host_write(4'd0, 8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    read_frame(8'hFE, 3, "burst_wrap", oa, od);
    check("burst_wrap sdo_oe bits", od, 24);

    // Several address/data pairs in one frame, one pair outside the window
    cs_low();
    write_frame(8'h70, 8'h01);
    write_frame(8'h71, 8'h02);
    write_frame(8'h10, 8'hFF);
    cs_high();
    exp_wr_q.push_back({4'h0, 8'h01});
    exp_wr_q.push_back({4'h1, 8'h02});
    check_writes("multi_pair");

    // Abort a write after 5 data bits
    cs_low();
    spi_byte(8'h72, -1, rx, c1);
    for (int i = 0; i < 5; i++) spi_bit(1'b1, 1'b0, so, oe);
    check("abort busy while csb low", busy, 1);
    cs_high();
    check("abort busy", busy, 0);
    check("abort sdo_oe", sdo_oe, 0);
    check_writes("abort");

    // Single-byte read table
    vecs[0] = '{8'hD0, 8'h58};
    vecs[1] = '{8'hD1, 8'h00};
    vecs[2] = '{8'hF0, 8'h01};
    vecs[3] = '{8'hF1, 8'h02};
    vecs[4] = '{8'hF2, 8'h00};
    vecs[5] = '{8'hF5, 8'hA5};
    vecs[6] = '{8'hFE, 8'h11};
    vecs[7] = '{8'hFF, 8'h22};
    vecs[8] = '{8'h90, 8'h00};
    vecs[9] = '{8'hEF, 8'h00};
    for (int v = 0; v < 10; v++) begin
      exp_q.push_back(vecs[v].exp);
      read_frame(vecs[v].cmd, 1, $sformatf("table[%0d] cmd %h", v, vecs[v].cmd), oa, od);
    end
    check_writes("table reads");

    // Host write and SPI commit to offset 3 in the same cycle
    cs_low();
    spi_byte(8'h73, -1, rx, c1);
    spi_byte(8'hAA, 0, rx, c1);
    cs_high();
    exp_wr_q.push_back({4'h3, 8'hAA});
    check_writes("collision");
    exp_q.push_back(8'hAA);
    read_frame(8'hF3, 1, "collision readback", oa, od);

    // Reset in the middle of a read
    cs_low();
    spi_byte(8'hF3, -1, rx, c1);
    for (int i = 2; i >= 0; i--) begin
      spi_bit(1'b0, 1'b0, so, oe);
      part[i] = so;
    end
    check("mid_read partial bits", part, 3'b101);
    check("mid_read wr_addr before reset", spi_wr_addr, 4'h3);
    @(negedge clk12MHz);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_read reset");
    repeat (3) @(negedge clk12MHz);
    rst_n = 1'b1;
    spi_byte(8'hD0, -1, rx, c1);
    spi_byte(8'h00, -1, rx, c2);
    check("no frame without fresh csb fall", c1 + c2, 0);
    cs_high();
    check_writes("after reset");
    exp_q.push_back(8'h00);
    read_frame(8'hF3, 1, "offset3 after reset", oa, od);
    exp_q.push_back(8'h00);
    read_frame(8'hF5, 1, "offset5 after reset", oa, od);
    check("scoreboard drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
